// File: rtl/wm_pkg.sv
// Shared types and default timing for the washing-machine appliance responder.
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILLING  = 3'd1,
        ST_WASHING  = 3'd2,
        ST_DRAINING = 3'd3,
        ST_SPINNING = 3'd4,
        ST_FAULT    = 3'd5
    } wm_state_e;

    localparam int WM_CW          = 8;
    localparam int WM_FILL_CYCLES = 16;
    localparam int WM_WASH_CYCLES = 32;
    localparam int WM_SPIN_CYCLES = 20;
    localparam int WM_DET_DELAY   = 4;

endpackage

// File: rtl/wm_sat_counter.sv
// Up/down counter saturating at 0 and MAX; at_max/at_zero describe the value being loaded
// this clock, so a register sampling them lands in the same edge as q.
module wm_sat_counter
    import wm_pkg::*;
#(
    parameter int CW  = WM_CW,
    parameter int MAX = WM_FILL_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    input  logic          hold,
    output logic [CW-1:0] q,
    output logic          at_max,
    output logic          at_zero
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    logic [CW-1:0] q_q, q_d;

    // hold outranks clr so a frozen plant keeps every timer exactly where it stopped
    always_comb begin
        q_d = q_q;
        if (hold)
            q_d = q_q;
        else if (clr)
            q_d = '0;
        else if (inc && !dec && q_q != MAX_V)
            q_d = q_q + 1'b1;
        else if (dec && !inc && q_q != '0)
            q_d = q_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q       = q_q;
    assign at_max  = (q_d == MAX_V);
    assign at_zero = (q_d == '0);

endmodule

// File: rtl/wm_appliance_responder.sv
// Closed-loop plant for the washing-machine controller: valve, pump, drum and door latch
// modelled with cycle-count timers, plus a sticky illegal-command detector.
module wm_appliance_responder
    import wm_pkg::*;
#(
    parameter int CW          = WM_CW,
    parameter int FILL_CYCLES = WM_FILL_CYCLES,
    parameter int WASH_CYCLES = WM_WASH_CYCLES,
    parameter int SPIN_CYCLES = WM_SPIN_CYCLES,
    parameter int DET_DELAY   = WM_DET_DELAY
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          door_sw,
    input  logic          detergent_sw,
    input  logic          door_lock_cmd,
    input  logic          fill_cmd,
    input  logic          motor_cmd,
    input  logic          drain_cmd,
    input  logic          spin_cmd,
    output logic          door_closed,
    output logic          water_full,
    output logic          detergent_added,
    output logic          wash_done,
    output logic          drain_done,
    output logic          spin_done,
    output logic [CW-1:0] level,
    output logic          fault
);

    wm_state_e     state_q;
    logic          fault_q, door_closed_q, water_full_q, det_added_q;
    logic          wash_done_q, drain_done_q, spin_done_q, det_sw_q, det_armed_q;
    logic [CW-1:0] level_q, wash_q, spin_q, det_q;
    logic          lvl_max, lvl_zero, wash_max, wash_zero, spin_max, spin_zero;
    logic          det_max, det_zero, det_rise, det_busy, fault_now, frz;
    logic          unused_ok;

    // Illegal command check uses the registered door/level the controller is reacting to
    assign fault_now = (fill_cmd & drain_cmd)
                     | (motor_cmd & ~door_closed_q)
                     | (spin_cmd & (level_q != '0))
                     | (fill_cmd & motor_cmd) | (fill_cmd & spin_cmd) | (motor_cmd & spin_cmd);
    assign frz       = fault_now | (state_q == ST_FAULT);
    assign det_rise  = detergent_sw & ~det_sw_q;
    assign det_busy  = det_rise | det_armed_q;

    wm_sat_counter #(.CW(CW), .MAX(FILL_CYCLES)) u_level (
        .clk(clk), .reset(reset), .inc(fill_cmd), .dec(drain_cmd), .clr(1'b0), .hold(frz),
        .q(level_q), .at_max(lvl_max), .at_zero(lvl_zero));

    wm_sat_counter #(.CW(CW), .MAX(WASH_CYCLES)) u_wash (
        .clk(clk), .reset(reset), .inc(motor_cmd & water_full_q & door_closed_q), .dec(1'b0),
        .clr(~motor_cmd), .hold(frz), .q(wash_q), .at_max(wash_max), .at_zero(wash_zero));

    wm_sat_counter #(.CW(CW), .MAX(SPIN_CYCLES)) u_spin (
        .clk(clk), .reset(reset), .inc(spin_cmd & (level_q == '0)), .dec(1'b0),
        .clr(~spin_cmd), .hold(frz), .q(spin_q), .at_max(spin_max), .at_zero(spin_zero));

    wm_sat_counter #(.CW(CW), .MAX(DET_DELAY)) u_det (
        .clk(clk), .reset(reset), .inc(det_armed_q & ~det_rise), .dec(1'b0),
        .clr(det_rise), .hold(frz), .q(det_q), .at_max(det_max), .at_zero(det_zero));

    assign unused_ok = &{1'b0, wash_zero, spin_zero, det_zero, spin_q, det_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            door_closed_q <= 1'b0;
            water_full_q  <= 1'b0;
            drain_done_q  <= 1'b0;
            det_sw_q      <= 1'b0;
            det_armed_q   <= 1'b0;
            det_added_q   <= 1'b0;
            wash_done_q   <= 1'b0;
            spin_done_q   <= 1'b0;
        end else if (!frz) begin
            door_closed_q <= door_sw | (door_lock_cmd & door_closed_q);
            water_full_q  <= lvl_max;
            drain_done_q  <= drain_cmd & lvl_zero;
            det_sw_q      <= detergent_sw;
            det_armed_q   <= det_busy & ~det_max;
            // An empty-and-draining tank flushes the detergent, even if it lands this edge
            if (drain_cmd && lvl_zero)
                det_added_q <= 1'b0;
            else if (det_busy && det_max)
                det_added_q <= 1'b1;
            wash_done_q   <= motor_cmd & (wash_done_q | wash_max);
            spin_done_q   <= spin_cmd & (spin_done_q | spin_max);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
        end else if (state_q != ST_FAULT) begin
            if (fault_now) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
            end else if (fill_cmd)
                state_q <= ST_FILLING;
            else if (drain_cmd)
                state_q <= ST_DRAINING;
            else if (motor_cmd)
                state_q <= ST_WASHING;
            else if (spin_cmd)
                state_q <= ST_SPINNING;
            else
                state_q <= ST_IDLE;
        end
    end

    assign door_closed     = door_closed_q;
    assign water_full      = water_full_q;
    assign detergent_added = det_added_q;
    assign wash_done       = wash_done_q;
    assign drain_done      = drain_done_q;
    assign spin_done       = spin_done_q;
    assign level           = level_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_wm_appliance_responder.sv
// Bench for wm_appliance_responder: directed scenarios with literal expectations, then
// randomized command segments checked every cycle against a behavioural plant model.
module tb_wm_appliance_responder;

    localparam int CW   = 8;
    localparam int FILL = 16;
    localparam int WASH = 32;
    localparam int SPIN = 20;
    localparam int DET  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic door_sw = 0, detergent_sw = 0, door_lock_cmd = 0;
    logic fill_cmd = 0, motor_cmd = 0, drain_cmd = 0, spin_cmd = 0;
    logic door_closed, water_full, detergent_added, wash_done, drain_done, spin_done, fault;
    logic [CW-1:0] level;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // behavioural plant state
    int m_level, m_wash, m_spin, m_rem;
    bit m_armed, m_dc, m_wf, m_det, m_wd, m_dd, m_sd, m_fault, m_detq;

    wm_appliance_responder #(.CW(CW), .FILL_CYCLES(FILL), .WASH_CYCLES(WASH),
                             .SPIN_CYCLES(SPIN), .DET_DELAY(DET)) dut (
        .clk(clk), .reset(reset), .door_sw(door_sw), .detergent_sw(detergent_sw),
        .door_lock_cmd(door_lock_cmd), .fill_cmd(fill_cmd), .motor_cmd(motor_cmd),
        .drain_cmd(drain_cmd), .spin_cmd(spin_cmd), .door_closed(door_closed),
        .water_full(water_full), .detergent_added(detergent_added), .wash_done(wash_done),
        .drain_done(drain_done), .spin_done(spin_done), .level(level), .fault(fault));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task model_reset();
        m_level = 0; m_wash = 0; m_spin = 0; m_rem = 0;
        m_armed = 0; m_dc = 0; m_wf = 0; m_det = 0; m_wd = 0; m_dd = 0; m_sd = 0;
        m_fault = 0; m_detq = 0;
    endtask

    task model_step();
        int nl, nw, ns, active;
        bit nd;
        if (reset) begin
            model_reset();
        end else if (!m_fault) begin
            active = int'(fill_cmd) + int'(motor_cmd) + int'(spin_cmd);
            if ((fill_cmd && drain_cmd) || (motor_cmd && !m_dc) ||
                (spin_cmd && m_level != 0) || active > 1) begin
                m_fault = 1;
            end else begin
                nl = m_level;
                if (fill_cmd && !drain_cmd && nl < FILL) nl = nl + 1;
                if (drain_cmd && !fill_cmd && nl > 0) nl = nl - 1;
                nw = m_wash;
                if (!motor_cmd) nw = 0;
                else if (m_wf && m_dc && nw < WASH) nw = nw + 1;
                ns = m_spin;
                if (!spin_cmd) ns = 0;
                else if (m_level == 0 && ns < SPIN) ns = ns + 1;
                if (detergent_sw && !m_detq) begin
                    m_rem = DET; m_armed = 1;
                end else if (m_armed && m_rem > 0) begin
                    m_rem = m_rem - 1;
                end
                nd = m_det;
                if (m_armed && m_rem == 0) begin
                    nd = 1; m_armed = 0;
                end
                if (drain_cmd && nl == 0) nd = 0;
                m_wd    = motor_cmd && (m_wd || nw == WASH);
                m_sd    = spin_cmd && (m_sd || ns == SPIN);
                m_dc    = door_sw || (door_lock_cmd && m_dc);
                m_wf    = (nl == FILL);
                m_dd    = drain_cmd && nl == 0;
                m_det   = nd;
                m_detq  = detergent_sw;
                m_level = nl; m_wash = nw; m_spin = ns;
            end
        end
    endtask

    always @(posedge reset) model_reset();

    always @(posedge clk) begin
        model_step();
        #2;
        if (chk_en) begin
            chk("level", int'(level), m_level);
            chk("water_full", int'(water_full), int'(m_wf));
            chk("detergent_added", int'(detergent_added), int'(m_det));
            chk("wash_done", int'(wash_done), int'(m_wd));
            chk("drain_done", int'(drain_done), int'(m_dd));
            chk("spin_done", int'(spin_done), int'(m_sd));
            chk("door_closed", int'(door_closed), int'(m_dc));
            chk("fault", int'(fault), int'(m_fault));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog at %0t: actual=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seg_len;
        logic [3:0] bits;
        cyc(2);
        reset = 1'b0;
        chk_en = 1;
        chk("rst_level", int'(level), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_door", int'(door_closed), 0);

        // fill to full with door latched, then open the door
        door_sw = 1; door_lock_cmd = 1;
        cyc(1);
        chk("door_shut", int'(door_closed), 1);
        fill_cmd = 1;
        cyc(15);
        chk("fill15_level", int'(level), 15);
        chk("fill15_full", int'(water_full), 0);
        cyc(1);
        chk("fill16_level", int'(level), 16);
        chk("fill16_full", int'(water_full), 1);
        fill_cmd = 0; door_sw = 0;
        cyc(1);
        chk("latched_door", int'(door_closed), 1);

        // wash
        motor_cmd = 1;
        cyc(31);
        chk("wash31", int'(wash_done), 0);
        cyc(1);
        chk("wash32", int'(wash_done), 1);
        motor_cmd = 0;
        cyc(1);
        chk("wash_off", int'(wash_done), 0);

        // detergent delay
        detergent_sw = 1;
        cyc(4);
        chk("det4", int'(detergent_added), 0);
        cyc(1);
        chk("det5", int'(detergent_added), 1);
        detergent_sw = 0;

        // drain then spin
        drain_cmd = 1;
        cyc(15);
        chk("drain15_level", int'(level), 1);
        chk("drain15_done", int'(drain_done), 0);
        chk("drain15_det", int'(detergent_added), 1);
        cyc(1);
        chk("drain16_level", int'(level), 0);
        chk("drain16_done", int'(drain_done), 1);
        chk("drain16_det", int'(detergent_added), 0);
        drain_cmd = 0; spin_cmd = 1;
        cyc(19);
        chk("spin19", int'(spin_done), 0);
        cyc(1);
        chk("spin20", int'(spin_done), 1);
        spin_cmd = 0;
        cyc(1);
        chk("spin_off", int'(spin_done), 0);

        // asynchronous reset mid-fill
        fill_cmd = 1;
        cyc(7);
        chk("prereset_level", int'(level), 7);
        reset = 1;
        #1;
        chk("async_level", int'(level), 0);
        chk("async_full", int'(water_full), 0);
        chk("async_fault", int'(fault), 0);
        chk("async_door", int'(door_closed), 0);
        cyc(1);
        reset = 0; fill_cmd = 0; door_lock_cmd = 0;

        // fill and drain together at level 5
        door_sw = 1; fill_cmd = 1;
        cyc(5);
        chk("pre_fault_level", int'(level), 5);
        drain_cmd = 1;
        cyc(1);
        chk("fd_fault", int'(fault), 1);
        cyc(10);
        chk("fd_level_hold", int'(level), 5);
        fill_cmd = 0; drain_cmd = 0;
        cyc(2);
        chk("fd_sticky", int'(fault), 1);
        pulse_reset();
        chk("fd_cleared", int'(fault), 0);

        // spin with water in the tank
        fill_cmd = 1;
        cyc(3);
        fill_cmd = 0; spin_cmd = 1;
        cyc(1);
        chk("spin_wet_fault", int'(fault), 1);
        chk("spin_wet_level", int'(level), 3);
        spin_cmd = 0;
        pulse_reset();

        // motor with the door open
        door_sw = 0;
        cyc(1);
        motor_cmd = 1;
        cyc(1);
        chk("motor_open_fault", int'(fault), 1);
        cyc(5);
        chk("motor_open_timer", int'(dut.wash_q), 0);
        motor_cmd = 0;
        pulse_reset();

        // randomized command segments
        for (int seg = 0; seg < 150; seg++) begin
            fill_cmd = 0; drain_cmd = 0; motor_cmd = 0; spin_cmd = 0;
            if ($urandom_range(0, 99) < 5) begin
                bits = 4'($urandom);
                fill_cmd = bits[0]; drain_cmd = bits[1]; motor_cmd = bits[2]; spin_cmd = bits[3];
            end else begin
                case ($urandom_range(0, 4))
                    1: fill_cmd = 1;
                    2: drain_cmd = 1;
                    3: motor_cmd = 1;
                    4: spin_cmd = (m_level == 0);
                    default: ;
                endcase
            end
            door_sw = ($urandom_range(0, 9) != 0);
            door_lock_cmd = 1'($urandom_range(0, 1));
            seg_len = $urandom_range(1, 40);
            for (int i = 0; i < seg_len; i++) begin
                if ($urandom_range(0, 7) == 0) detergent_sw = ~detergent_sw;
                cyc(1);
            end
            if (m_fault || $urandom_range(0, 19) == 0) pulse_reset();
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
